// File: rtl/rx_sweep_pkg.sv
// Shared types and constants for the receiver sweep scheduler.
// Used by rx_sweep_sched, rx_sweep_hold and rx_sweep_sched_if.
package rx_sweep_pkg;

    localparam int IQ_W = 24;
    localparam logic [1:0] TUSER_SOF = 2'b01;
    localparam int MAX_NR = 8;

    typedef enum logic [1:0] {
        IDLE,
        SEND_I,
        SEND_Q
    } state_t;

    // Number of receivers taking part in a sweep: channels+1, clamped to the build size.
    function automatic logic [3:0] active_count(input logic [3:0] channels, input int nr);
        int n;
        n = int'(channels) + 1;
        if (n > nr) n = nr;
        if (n > MAX_NR) n = MAX_NR;
        return 4'(n);
    endfunction

endpackage

// File: rtl/rx_sweep_sched_if.sv
// AXI-stream style output bus of rx_sweep_sched towards the usiq_fifo write port.
interface rx_sweep_sched_if;
    import rx_sweep_pkg::*;

    logic [IQ_W-1:0] rx_tdata;
    logic            rx_tvalid;
    logic            rx_tready;
    logic            rx_tlast;
    logic [1:0]      rx_tuser;

    modport master (
        output rx_tdata,
        output rx_tvalid,
        output rx_tlast,
        output rx_tuser,
        input  rx_tready
    );

    modport slave (
        input  rx_tdata,
        input  rx_tvalid,
        input  rx_tlast,
        input  rx_tuser,
        output rx_tready
    );

endinterface

// File: rtl/rx_sweep_hold.sv
// Per-receiver sample holding register with pending and sticky overrun flags.
// With RX_SWEEP_OVR_CNT_EN defined, also carries a saturating overrun counter (ovr_cnt).
module rx_sweep_hold
    import rx_sweep_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cap,
    input  logic              rel,
    input  logic              flush,
    input  logic              clr,
    input  logic [2*IQ_W-1:0] din,
    output logic [2*IQ_W-1:0] hold,
    output logic              pend,
    output logic              ovr
`ifdef RX_SWEEP_OVR_CNT_EN
    ,
    output logic [CNT_W-1:0]  ovr_cnt
`endif
);

    logic ovr_ev;

    // A sample arriving while its predecessor's Q word is being accepted is a refill, not an overrun.
    assign ovr_ev = cap && pend && !rel;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold <= '0;
            pend <= 1'b0;
            ovr  <= 1'b0;
        end else begin
            if (cap && (!pend || rel)) hold <= din;

            if (flush)     pend <= 1'b0;
            else if (cap)  pend <= 1'b1;
            else if (rel)  pend <= 1'b0;

            if (ovr_ev)    ovr <= 1'b1;
            else if (clr)  ovr <= 1'b0;
        end
    end

`ifdef RX_SWEEP_OVR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_cnt <= '0;
        end else if (ovr_ev) begin
            if (clr)             ovr_cnt <= CNT_W'(1);
            else if (!(&ovr_cnt)) ovr_cnt <= ovr_cnt + CNT_W'(1);
        end else if (clr) begin
            ovr_cnt <= '0;
        end
    end
`endif

endmodule

// File: rtl/rx_sweep_sched.sv
// Round-robin scheduler: one IQ sample per active receiver, emitted as a tlast-framed sweep.
// Optional macro RX_SWEEP_OVR_CNT_EN adds per-channel saturating overrun counters (ovr_cnt).
module rx_sweep_sched
    import rx_sweep_pkg::*;
#(
    parameter int NR    = 1,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           channels,
    input  logic [NR-1:0]        ch_valid,
    input  logic [NR*48-1:0]     ch_data,
    rx_sweep_sched_if.master     rx,
    output logic [NR-1:0]        overrun,
    input  logic                 clr_status
`ifdef RX_SWEEP_OVR_CNT_EN
    ,
    output logic [NR*CNT_W-1:0]  ovr_cnt
`endif
);

    localparam int IDX_W = (NR > 1) ? $clog2(NR) : 1;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d, idx_inc;
    logic [3:0]        act_r, act_next, nact;
    logic [2*IQ_W-1:0] hold [NR];
    logic [NR-1:0]     pend, act_mask, keep_mask, cap, rel, flush;
    logic              all_pend, accept, q_accept, last_ch;
    logic              tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic [1:0]        tuser_q, tuser_d;
    logic [IQ_W-1:0]   tdata_q, tdata_d;

    assign nact     = active_count(channels, NR);
    assign act_next = (state_q == IDLE) ? nact : act_r;
    assign accept   = tvalid_q && rx.rx_tready;
    assign q_accept = accept && (state_q == SEND_Q);
    assign idx_inc  = idx_q + IDX_W'(1);
    assign last_ch  = (4'(idx_q) == act_r - 4'd1);

    always_ff @(posedge clk) begin
        if (rst)                   act_r <= 4'd1;
        else if (state_q == IDLE)  act_r <= nact;
    end

    // Channels beyond the upcoming active count are flushed on the same edge act_r shrinks.
    always_comb begin
        act_mask  = '0;
        keep_mask = '0;
        rel       = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            act_mask[k]  = 4'(k) < act_r;
            keep_mask[k] = 4'(k) < act_next;
            rel[k]       = q_accept && (idx_q == IDX_W'(k));
        end
    end

    assign cap      = ch_valid & act_mask;
    assign flush    = ~keep_mask;
    assign all_pend = &(pend | ~keep_mask);

    for (genvar k = 0; k < NR; k++) begin : g_ch
        rx_sweep_hold #(.CNT_W(CNT_W)) u_hold (
            .clk     (clk),
            .rst     (rst),
            .cap     (cap[k]),
            .rel     (rel[k]),
            .flush   (flush[k]),
            .clr     (clr_status),
            .din     (ch_data[48*k +: 48]),
            .hold    (hold[k]),
            .pend    (pend[k]),
            .ovr     (overrun[k])
`ifdef RX_SWEEP_OVR_CNT_EN
            ,
            .ovr_cnt (ovr_cnt[CNT_W*k +: CNT_W])
`endif
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tuser_q  <= '0;
            tdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tuser_q  <= tuser_d;
            tdata_q  <= tdata_d;
        end
    end

    // Next-word values are computed here and registered, so outputs only move on accept.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tuser_d  = tuser_q;
        tdata_d  = tdata_q;
        case (state_q)
            IDLE: begin
                if (all_pend) begin
                    state_d  = SEND_I;
                    idx_d    = '0;
                    tvalid_d = 1'b1;
                    tdata_d  = hold[0][2*IQ_W-1:IQ_W];
                    tuser_d  = TUSER_SOF;
                    tlast_d  = 1'b0;
                end
            end
            SEND_I: begin
                if (accept) begin
                    state_d = SEND_Q;
                    tdata_d = hold[idx_q][IQ_W-1:0];
                    tuser_d = '0;
                    tlast_d = last_ch;
                end
            end
            SEND_Q: begin
                if (accept) begin
                    tuser_d = '0;
                    tlast_d = 1'b0;
                    if (last_ch) begin
                        state_d  = IDLE;
                        tvalid_d = 1'b0;
                    end else begin
                        state_d = SEND_I;
                        idx_d   = idx_inc;
                        tdata_d = hold[idx_inc][2*IQ_W-1:IQ_W];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx.rx_tvalid = tvalid_q;
    assign rx.rx_tdata  = tdata_q;
    assign rx.rx_tuser  = tuser_q;
    assign rx.rx_tlast  = tlast_q;

endmodule

// File: tb/tb_rx_sweep_sched.sv
// Self-checking bench for rx_sweep_sched (NR=4) against a transaction-level sweep model.
module tb_rx_sweep_sched;
    import rx_sweep_pkg::*;

    localparam int NR    = 4;
    localparam int CNT_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        channels;
    logic [NR-1:0]     ch_valid;
    logic [NR*48-1:0]  ch_data;
    logic [NR-1:0]     overrun;
    logic              clr_status;
`ifdef RX_SWEEP_OVR_CNT_EN
    logic [NR*CNT_W-1:0] ovr_cnt;
`endif

    rx_sweep_sched_if rxif ();

    rx_sweep_sched #(.NR(NR), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .channels   (channels),
        .ch_valid   (ch_valid),
        .ch_data    (ch_data),
        .rx         (rxif),
        .overrun    (overrun),
        .clr_status (clr_status)
`ifdef RX_SWEEP_OVR_CNT_EN
        ,
        .ovr_cnt    (ovr_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] d;
        logic [1:0]  u;
        logic        l;
    } word_t;

    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    int    first_cyc = -1;
    int    stab_err = 0;
    word_t got[$];
    word_t exp_q[$];

    // Reference model: one pending sample per channel, a sweep drains all active channels.
    logic [47:0]   m_hold [NR];
    bit            m_pend [NR];
    logic [NR-1:0] m_ovr;
    int            m_act;

    function automatic void m_strobe(int k, logic [47:0] v);
        if (k >= m_act) return;
        if (m_pend[k]) m_ovr[k] = 1'b1;
        else begin
            m_hold[k] = v;
            m_pend[k] = 1'b1;
        end
    endfunction

    function automatic void m_sweep();
        for (int k = 0; k < m_act; k++) begin
            exp_q.push_back('{m_hold[k][47:24], (k == 0) ? 2'b01 : 2'b00, 1'b0});
            exp_q.push_back('{m_hold[k][23:0], 2'b00, (k == m_act - 1)});
            m_pend[k] = 1'b0;
        end
    endfunction

    function automatic void m_set_act(int n);
        m_act = n;
        for (int k = n; k < NR; k++) m_pend[k] = 1'b0;
    endfunction

    function automatic logic [47:0] rand48();
        return {24'($urandom), 24'($urandom)};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    word_t prev_w;
    bit    prev_stall = 1'b0;
    always @(negedge clk) begin
        word_t w;
        w = '{rxif.rx_tdata, rxif.rx_tuser, rxif.rx_tlast};
        if (prev_stall && (rxif.rx_tvalid !== 1'b1 || w !== prev_w)) stab_err++;
        if (rxif.rx_tvalid === 1'b1 && rxif.rx_tready === 1'b1) got.push_back(w);
        if (rxif.rx_tvalid === 1'b1 && first_cyc < 0) first_cyc = cyc;
        prev_stall = (rxif.rx_tvalid === 1'b1) && (rxif.rx_tready === 1'b0);
        prev_w = w;
    end

    task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(int k, logic [47:0] v);
        ch_valid[k] = 1'b1;
        ch_data[48*k +: 48] = v;
        m_strobe(k, v);
        step();
        ch_valid = '0;
    endtask

    task automatic collect(int n, int mode);
        int budget;
        budget = 300;
        while (got.size() < n && budget > 0) begin
            case (mode)
                0:       rxif.rx_tready = 1'b1;
                1:       rxif.rx_tready = ~rxif.rx_tready;
                default: rxif.rx_tready = 1'($urandom_range(0, 1));
            endcase
            step();
            budget--;
        end
        check("collect_count", 64'(got.size()), 64'(n));
    endtask

    task automatic compare_words(string tag);
        word_t e, g;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got.size() > 0) g = got.pop_front();
            else g = 'x;
            check(tag, 64'(g), 64'(e));
        end
        check({tag, "_extra"}, 64'(got.size()), 64'd0);
        got.delete();
    endtask

    task automatic wait_valid();
        int budget;
        budget = 50;
        while (rxif.rx_tvalid !== 1'b1 && budget > 0) begin
            step();
            budget--;
        end
        check("wait_valid", 64'(rxif.rx_tvalid), 64'd1);
    endtask

    initial begin
        int cap_cyc;
        rst = 1'b1;
        channels = 4'd3;
        ch_valid = '0;
        ch_data = '0;
        clr_status = 1'b0;
        rxif.rx_tready = 1'b1;
        m_act = 4;
        m_ovr = '0;
        for (int k = 0; k < NR; k++) begin
            m_pend[k] = 1'b0;
            m_hold[k] = '0;
        end

        repeat (3) step();
        check("rst_tvalid", 64'(rxif.rx_tvalid), 64'd0);
        check("rst_tlast", 64'(rxif.rx_tlast), 64'd0);
        check("rst_tuser", 64'(rxif.rx_tuser), 64'd0);
        check("rst_tdata", 64'(rxif.rx_tdata), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        rst = 1'b0;
        step();
        step();

        // Basic 4-channel sweep with fixed data and full-rate ready
        first_cyc = -1;
        for (int k = 0; k < 4; k++) strobe(k, {24'(k * 16 + 1), 24'(k * 16 + 2)});
        cap_cyc = cyc;
        m_sweep();
        collect(8, 0);
        compare_words("sweep_basic");
        check("first_latency", 64'(first_cyc), 64'(cap_cyc + 1));
        check("idle_gap", 64'(rxif.rx_tvalid), 64'd0);

        // Ready toggling every cycle
        for (int k = 0; k < 4; k++) strobe(k, rand48());
        m_sweep();
        stab_err = 0;
        collect(8, 1);
        compare_words("sweep_toggle");
        check("hold_stable", 64'(stab_err), 64'd0);

        // Overrun on ch1 before the sweep, random backpressure
        rxif.rx_tready = 1'b1;
        strobe(0, rand48());
        strobe(1, rand48());
        strobe(2, rand48());
        strobe(1, rand48());
        check("overrun_set", 64'(overrun), 64'(m_ovr));
        check("overrun_ch1", 64'(m_ovr), 64'h2);
        strobe(3, rand48());
        m_sweep();
        stab_err = 0;
        collect(8, 2);
        compare_words("sweep_drop");
        check("hold_stable_rand", 64'(stab_err), 64'd0);
        check("overrun_kept", 64'(overrun), 64'(m_ovr));
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        m_ovr = '0;
        check("overrun_clr", 64'(overrun), 64'(m_ovr));

        // New ch0 sample on the exact cycle its Q word is accepted
        rxif.rx_tready = 1'b0;
        for (int k = 0; k < 4; k++) strobe(k, rand48());
        m_sweep();
        wait_valid();
        rxif.rx_tready = 1'b1;
        step();
        strobe(0, rand48());
        collect(8, 0);
        compare_words("sweep_q_accept");
        check("no_overrun_refill", 64'(overrun), 64'(m_ovr));
        for (int k = 1; k < 4; k++) strobe(k, rand48());
        m_sweep();
        collect(8, 0);
        compare_words("sweep_new_ch0");

        // Active count shrinks mid-sweep, stale ch2 pend must be flushed
        rxif.rx_tready = 1'b0;
        for (int k = 0; k < 4; k++) strobe(k, rand48());
        m_sweep();
        wait_valid();
        rxif.rx_tready = 1'b1;
        repeat (4) step();
        rxif.rx_tready = 1'b0;
        channels = 4'd1;
        step();
        check("mid_sweep_valid", 64'(rxif.rx_tvalid), 64'd1);
        rxif.rx_tready = 1'b1;
        step();
        step();
        rxif.rx_tready = 1'b0;
        strobe(2, rand48());
        collect(8, 0);
        compare_words("sweep_shrink_mid");
        m_set_act(2);
        strobe(0, rand48());
        strobe(1, rand48());
        m_sweep();
        collect(4, 0);
        compare_words("sweep_two_ch");
        channels = 4'd3;
        m_set_act(4);
        step();
        step();
        first_cyc = -1;
        strobe(0, rand48());
        strobe(1, rand48());
        strobe(3, rand48());
        repeat (10) step();
        check("stale_pend_flushed", 64'(first_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
        strobe(2, rand48());
        m_sweep();
        collect(8, 0);
        compare_words("sweep_regrow");
        check("overrun_final", 64'(overrun), 64'(m_ovr));

`ifdef RX_SWEEP_OVR_CNT_EN
        strobe(0, rand48());
        repeat (20) strobe(0, rand48());
        check("ovr_cnt_sat", 64'(ovr_cnt[CNT_W-1:0]), 64'hF);
        check("ovr_cnt_flag", 64'(overrun), 64'(m_ovr));
        rst = 1'b1;
        step();
        check("ovr_cnt_rst", 64'(ovr_cnt), 64'd0);
        rst = 1'b0;
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rx_sweep_sched.md
Name: rx_sweep_sched

Overview:
- Round-robin scheduler between the NR receiver DDC outputs of radio and the usiq_fifo write port.
- Holds one IQ sample per active receiver, then emits one "sweep" containing every active receiver's I and Q, in channel order, as 24-bit AXI-stream words.
- tlast marks the end of each sweep, so the Pi-side reader stays aligned to receiver 0.
- Reports per-receiver overrun when a DDC produces a new sample before its previous one has been sent.

Parameters:
- NR, 1, number of receiver channels (1..8).
- CNT_W, 16, width of the optional per-channel overrun counters.

Ports:
- clk  in  1  clk_ad9866 domain clock.
- rst  in  1  synchronous active-high reset.
- channels  in  4  active receiver count minus one, taken from cmd_data[6:3].
- ch_valid  in  NR  one-cycle strobe per receiver: new sample on ch_data.
- ch_data  in  NR*48  per receiver {I[23:0],Q[23:0]}; receiver k occupies bits [48k+47:48k].
- rx_tdata  out  24  output word.
- rx_tvalid  out  1  output word valid.
- rx_tready  in  1  FIFO ready.
- rx_tlast  out  1  last word of the sweep (Q of the highest active channel).
- rx_tuser  out  2  2'b01 = I word of channel 0; 2'b00 = any other word.
- overrun  out  NR  sticky per-channel overrun flags.
- clr_status  in  1  one-cycle pulse that clears overrun (and the counters, when compiled in).

Behaviour:
- Reset: all pending flags 0, all holding registers 0, state IDLE; rx_tvalid=0, rx_tlast=0, rx_tuser=0, rx_tdata=0, overrun=0.
- Active count: nact = min(channels+1, NR).
  - Latched into act_r only while in IDLE.
  - When act_r changes, pending flags for channels >= new nact are cleared on the same cycle.
- Capture, per channel k < act_r:
  - ch_valid[k] with pend[k]=0 loads hold[k] and sets pend[k].
  - ch_valid[k] with pend[k]=1 drops the sample (hold[k] unchanged) and sets overrun[k].
  - Exception: if pend[k] is being cleared this cycle by acceptance of channel k's Q word, the new sample is loaded and pend[k] stays 1. This is not an overrun.
  - ch_valid on channels >= act_r is ignored.
- FSM states:
  - IDLE: when all pend[0..act_r-1]=1, set idx=0 and go to SEND_I. rx_tvalid rises the next cycle, so latency from the last capture to the first word is 1 cycle.
  - SEND_I: rx_tdata=hold[idx][47:24]; rx_tuser=2'b01 if idx=0, otherwise 2'b00. On rx_tvalid&rx_tready go to SEND_Q.
  - SEND_Q: rx_tdata=hold[idx][23:0]; rx_tlast=(idx==act_r-1). On accept, clear pend[idx].
    - If this was the last channel: go to IDLE.
    - Otherwise: idx+1, go to SEND_I.
- Output registers:
  - All rx_* outputs are registered.
  - rx_tvalid, rx_tdata, rx_tuser and rx_tlast are held stable while rx_tready=0.
  - Back-to-back accepts give 1 word per cycle with no bubbles inside a sweep.
  - There is 1 idle cycle (IDLE) between sweeps.
- clr_status together with a new overrun event on the same cycle: the set wins.
- rst mid-sweep: output drops immediately and all pend flags clear. The partially written sweep is the FIFO's problem; top level pulses wr_aclr alongside rst.

Optional Feature:
- Macro: RX_SWEEP_OVR_CNT_EN.
- Defined:
  - Adds output ovr_cnt (NR*CNT_W): one saturating counter per channel, incremented on each overrun event and stuck at all-ones.
  - The counters are cleared by clr_status or rst.
- Undefined: port absent and no counters; overrun flags only.

Decomposition:
- Package rx_sweep_pkg:
  - state enum {IDLE, SEND_I, SEND_Q}.
  - Constants IQ_W=24 and TUSER_SOF=2'b01.
  - MAX_NR=8.
- Sub-module rx_sweep_hold: one per channel, generated NR times. It contains the holding register, pend flag, overrun flag and optional counter, with capture, release and clear inputs.

Test Plan:
- NR=4, channels=3: strobe ch0..ch3 with I=k*16+1, Q=k*16+2, rx_tready=1 → words 000001,000002,000011,000012,000021,000022,000031,000032. tuser=01 only on the first word, tlast only on 000032, first tvalid 1 cycle after ch3 is captured.
- rx_tready toggling 1/0 every cycle during a sweep → each word held until accepted, same 8-word order, nothing duplicated or lost.
- ch1 strobed twice before the sweep starts → second sample dropped, overrun=4'b0010, sweep carries the first ch1 sample. clr_status → overrun=0.
- ch0 strobe on the exact cycle its Q word is accepted → no overrun, the next sweep carries the new ch0 sample.
- channels changed 3→1 during SEND_I of ch2 → current 4-channel sweep completes. The next sweep has 4 words with tlast on ch1's Q. Stale pend on ch2/ch3 is cleared.
- With RX_SWEEP_OVR_CNT_EN and CNT_W=4: 20 overruns on ch0 → ovr_cnt[3:0]=4'hF; rst → 0.
